// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, channel count and types for the PWM output stage
package pwm_pkg;
    localparam int PWM_WIDTH = 8;
    localparam int NUM_CH = 16;
    localparam int CLK_DIV_DEFAULT = 13;
    localparam logic [PWM_WIDTH-1:0] DUTY_FULL = 8'hFF;
    typedef logic [NUM_CH-1:0] ch_mask_t;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit period counter shared by all PWM channels
// Ports: clk, rst (async, active high); pwm_cnt = period position,
// tick = prescaler terminal count, wrap = last tick of a period (255 -> 0).
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PWM_WIDTH-1:0] pwm_cnt,
    output logic                 tick,
    output logic                 wrap
);
    logic [7:0] div_cnt;

    assign tick = div_cnt == 8'(CLK_DIV - 1);
    assign wrap = tick && pwm_cnt == '1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 8'd1;
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(tick);
        end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel PWM output stage fed by the SPI enable/duty registers
// Ports: clk, rst (async, active high); en_reg_out_* = per-channel output enable,
// en_reg_pwm_* = per-channel PWM select, pwm_duty_cycle = shared duty (0xFF = 100 %);
// out = registered pins, period_start = one-clk pulse when a new period begins.
// Build option PWM_DUTY_SHADOW_EN: duty is latched at each period boundary so a
// duty write never reshapes the period in flight; otherwise duty acts immediately.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int NUM_CH = pwm_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);
    ch_mask_t              en_out, en_pwm;
    logic [PWM_WIDTH-1:0]  pwm_cnt, duty_eff;
    logic                  tick, wrap, pwm_lvl;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk(clk),
        .rst(rst),
        .pwm_cnt(pwm_cnt),
        .tick(tick),
        .wrap(wrap)
    );

`ifdef PWM_DUTY_SHADOW_EN
    logic [PWM_WIDTH-1:0] duty_shadow;

    always_ff @(posedge clk or posedge rst)
        if (rst) duty_shadow <= '0;
        else if (wrap) duty_shadow <= pwm_duty_cycle;

    assign duty_eff = duty_shadow;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // full scale is forced high so 0xFF has no low state at count 255
    assign pwm_lvl = duty_eff == DUTY_FULL || pwm_cnt < duty_eff;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= en_out & (~en_pwm | {NUM_CH{pwm_lvl}});
            period_start <= wrap;
        end

    // a period can only end on a prescaler step
    assert property (@(posedge clk) disable iff (rst) wrap |-> tick);
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: randomized and directed checks of pwm_peripheral against a time-based model
module tb_pwm_peripheral;
    localparam int D = 13;
    localparam int P = 256 * D;

    logic        clk = 1'b0, rst = 1'b0;
    logic [7:0]  eo_l = '0, eo_h = '0, ep_l = '0, ep_h = '0, duty = '0;
    logic [15:0] out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(D)) dut (
        .clk(clk),
        .rst(rst),
        .en_reg_out_7_0(eo_l),
        .en_reg_out_15_8(eo_h),
        .en_reg_pwm_7_0(ep_l),
        .en_reg_pwm_15_8(ep_h),
        .pwm_duty_cycle(duty),
        .out(out),
        .period_start(period_start)
    );

    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Model: after k clock edges since reset the counter reads (k / D) % 256,
    // and a new period begins every P edges; pins follow that one edge later.
    longint      n;
    logic [15:0] exp_out;
    logic        exp_ps;
    logic [7:0]  duty_at_wrap;
    logic [7:0]  duty_m;

`ifdef PWM_DUTY_SHADOW_EN
    assign duty_m = duty_at_wrap;
`else
    assign duty_m = duty;
`endif

    function automatic logic [15:0] ref_out(longint k, logic [7:0] d, logic [15:0] eo, logic [15:0] ep);
        int   cnt = int'((k / D) % 256);
        logic lvl = (d == 8'hFF) || (cnt < int'(d));
        return eo & (~ep | {16{lvl}});
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            n            <= 0;
            exp_out      <= '0;
            exp_ps       <= 1'b0;
            duty_at_wrap <= '0;
        end else begin
            n       <= n + 1;
            exp_out <= ref_out(n, duty_m, {eo_h, eo_l}, {ep_h, ep_l});
            exp_ps  <= ((n + 1) % P) == 0;
            if (((n + 1) % P) == 0) duty_at_wrap <= duty;
        end

    always @(negedge clk)
        if (chk_on) begin
            chk("model_out", 32'(out), 32'(exp_out));
            chk("model_period_start", 32'(period_start), 32'(exp_ps));
        end

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {eo_h, eo_l} = eo;
        {ep_h, ep_l} = ep;
    endtask

    task automatic wait_ps(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!period_start && cyc < 2 * P);
        if (!period_start) begin
            checks++;
            errors++;
            $display("FAIL wait_period_start timeout got 0 want 1 after %0d clks", cyc);
        end
    endtask

    task automatic count_high(input int ch, input int len, output int hi);
        hi = 0;
        repeat (len) begin
            @(negedge clk);
            hi += int'(out[ch]);
        end
    endtask

    int cyc, hi, bad;

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_period_start", 32'(period_start), 32'h0);
        rst = 1'b0;
        chk_on = 1'b1;

        // reset mid-period
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'h80;
        repeat (1000) @(negedge clk);
        chk("pre_reset_out", 32'(out), 32'hFFFF);
        #2 rst = 1'b1;
        #1 chk("async_reset_out", 32'(out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ps(cyc);
        chk("first_period_len", 32'(cyc), 32'(P));

        // 50 % duty, and period spacing
        count_high(5, P, hi);
        chk("duty80_high", 32'(hi), 32'd1664);
        chk("period_spacing", 32'(period_start), 32'h1);

        // static modes
        set_en(16'h00FF, 16'h0000);
        count_high(8, 2 * P, hi);
        chk("static_ch8_high", 32'(hi), 32'd0);
        chk("static_out", 32'(out), 32'h00FF);

        // duty extremes
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'h00;
        wait_ps(cyc);
        count_high(3, 2 * P, hi);
        chk("duty00_high", 32'(hi), 32'd0);
        duty = 8'hFF;
        wait_ps(cyc);
        count_high(3, 2 * P, hi);
        chk("dutyFF_high", 32'(hi), 32'(2 * P));

        // duty change mid-period
        duty = 8'h40;
        wait_ps(cyc);
        hi = 0;
        for (int j = 0; j < P; j++) begin
            @(negedge clk);
            hi += int'(out[1]);
            if (j == 32 * D) duty = 8'hC0;
        end
`ifdef PWM_DUTY_SHADOW_EN
        chk("duty_change_cur_period", 32'(hi), 32'd832);
`else
        chk("duty_change_cur_period", 32'(hi), 32'd2496);
`endif
        count_high(1, P, hi);
        chk("duty_change_next_period", 32'(hi), 32'd2496);

        // mixed channels
        set_en(16'hF0F0, 16'hFF00);
        duty = 8'h40;
        wait_ps(cyc);
        hi = 0;
        bad = 0;
        repeat (P) begin
            @(negedge clk);
            hi += int'(out[12]);
            bad += int'((out & 16'h0FFF) != 16'h00F0);
            bad += int'(out[15:12] != {4{out[12]}});
        end
        chk("mixed_ch12_high", 32'(hi), 32'd832);
        chk("mixed_static_bits", 32'(bad), 32'd0);

        // randomized enables, duty and one asynchronous reset
        for (int j = 0; j < 3 * P; j++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) set_en(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0: duty = 8'h00;
                    1: duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
            end
            if (j == P + 777) begin
                #($urandom_range(1, 8)) rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
